// File: rtl/vs_vmm_acc.sv
// Systolic vector x matrix engine: per-column skewed MAC, K-accumulation and output deskew.
// Optional VS_VMM_SAT_EN clamps each lane result to the OUT_W range before deskew.
module vs_vmm_acc #(
  parameter  int unsigned DW        = 8,
  parameter  int unsigned TIN       = 4,
  parameter  int unsigned TOUT      = 4,
  parameter  int unsigned ACC_GUARD = 8,
  parameter  int unsigned OUT_W     = 16,
  localparam int unsigned PROD_W    = 2 * DW,
  localparam int unsigned ACC_W     = PROD_W + $clog2(TIN) + ACC_GUARD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_vld,
  input  logic                     i_last,
  input  logic                     i_mode,
  input  logic [DW*TIN-1:0]        i_dat,
  input  logic [DW*TIN*TOUT-1:0]   i_wt,
  output logic                     o_vld,
  output logic [ACC_W*TOUT-1:0]    o_dat
);

  if (OUT_W < 2 || OUT_W >= ACC_W) begin : g_bad_out_w
    $error("vs_vmm_acc: OUT_W must lie in [2, ACC_W-1]");
  end

  function automatic logic [ACC_W-1:0] ext(input logic [DW-1:0] v, input logic sgn);
    ext = {{(ACC_W-DW){sgn & v[DW-1]}}, v};
  endfunction

`ifdef VS_VMM_SAT_EN
  function automatic logic [ACC_W-1:0] clamp(input logic [ACC_W-1:0] a, input logic sgn);
    logic [ACC_W-1:0] smax, smin, umax;
    smax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    smin = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    umax = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    clamp = a;
    if (sgn) begin
      if ($signed(a) > $signed(smax))      clamp = smax;
      else if ($signed(a) < $signed(smin)) clamp = smin;
    end else if (a > umax) begin
      clamp = umax;
    end
  endfunction
`endif

  // Shared skew chain: index 0 is the stage-0 register, index j feeds column j.
  logic [DW*TIN-1:0]      dat_q [TOUT];
  logic [TOUT-1:0]        vld_q;
  logic [TOUT-1:0]        last_q;
  logic [TOUT-1:0]        mode_q;
  logic [DW*TIN*TOUT-1:0] wt0_q;
  logic                   last_done;
  logic                   res_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TOUT; i++) dat_q[i] <= '0;
      vld_q  <= '0;
      last_q <= '0;
      mode_q <= '0;
      wt0_q  <= '0;
    end else begin
      dat_q[0]  <= i_dat;
      vld_q[0]  <= i_vld;
      last_q[0] <= i_last;
      mode_q[0] <= i_mode;
      wt0_q     <= i_wt;
      for (int unsigned i = 1; i < TOUT; i++) begin
        dat_q[i]  <= dat_q[i-1];
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
        mode_q[i] <= mode_q[i-1];
      end
    end
  end

  for (genvar j = 0; j < TOUT; j++) begin : g_col
    logic [DW*TIN-1:0] wt_c;
    logic [ACC_W-1:0]  prod_d;
    logic [ACC_W-1:0]  mac_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  res_d;
    logic [ACC_W-1:0]  res_q;
    logic [ACC_W-1:0]  lane;
    logic              mac_vld_q;
    logic              mac_last_q;
    logic              first_q;
    logic              done_q;

    // Weights enter the chain at stage 0 and only this column's slice is delayed.
    if (j == 0) begin : g_w0
      assign wt_c = wt0_q[0 +: DW*TIN];
    end else begin : g_wsk
      logic [DW*TIN-1:0] wsk_q [j];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < j; i++) wsk_q[i] <= '0;
        end else begin
          wsk_q[0] <= wt0_q[j*DW*TIN +: DW*TIN];
          for (int unsigned i = 1; i < j; i++) wsk_q[i] <= wsk_q[i-1];
        end
      end
      assign wt_c = wsk_q[j-1];
    end

    always_comb begin
      prod_d = '0;
      for (int unsigned k = 0; k < TIN; k++) begin
        prod_d = prod_d + ext(dat_q[j][k*DW +: DW], mode_q[j]) *
                          ext(wt_c[k*DW +: DW], mode_q[j]);
      end
    end

`ifdef VS_VMM_SAT_EN
    logic mac_mode_q;
    logic done_mode_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mac_mode_q  <= 1'b0;
        done_mode_q <= 1'b0;
      end else begin
        mac_mode_q <= mode_q[j];
        if (mac_vld_q) done_mode_q <= mac_mode_q;
      end
    end
    assign res_d = clamp(acc_q, done_mode_q);
`else
    assign res_d = acc_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mac_q      <= '0;
        mac_vld_q  <= 1'b0;
        mac_last_q <= 1'b0;
        acc_q      <= '0;
        first_q    <= 1'b1;
        done_q     <= 1'b0;
        res_q      <= '0;
      end else begin
        mac_q      <= prod_d;
        mac_vld_q  <= vld_q[j];
        mac_last_q <= last_q[j];
        if (mac_vld_q) begin
          acc_q   <= first_q ? mac_q : acc_q + mac_q;
          first_q <= mac_last_q;
        end
        done_q <= mac_vld_q & mac_last_q;
        if (done_q) res_q <= res_d;
      end
    end

    if (j == TOUT-1) begin : g_tap
      assign last_done = done_q;
      assign lane      = res_q;
    end else begin : g_dsk
      logic [ACC_W-1:0] dsk_q [TOUT-1-j];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < TOUT-1-j; i++) dsk_q[i] <= '0;
        end else begin
          dsk_q[0] <= res_q;
          for (int unsigned i = 1; i < TOUT-1-j; i++) dsk_q[i] <= dsk_q[i-1];
        end
      end
      assign lane = dsk_q[TOUT-2-j];
    end

    assign o_dat[j*ACC_W +: ACC_W] = lane;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_vld_q <= 1'b0;
    else        res_vld_q <= last_done;
  end

  assign o_vld = res_vld_q;

endmodule

// File: tb/tb_vs_vmm_acc.sv
// Scoreboard bench for vs_vmm_acc: a behavioural model queues expected groups at drive time.
`timescale 1ns/1ps
module tb_vs_vmm_acc;
  localparam int unsigned DW    = 8;
  localparam int unsigned TIN   = 4;
  localparam int unsigned TOUT  = 4;
  localparam int unsigned GUARD = 8;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned ACC_W = 2*DW + 2 + GUARD;
  localparam int unsigned LAT   = TOUT + 3;

  typedef struct {
    logic [ACC_W*TOUT-1:0] dat;
    int unsigned           cyc;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   i_vld = 1'b0;
  logic                   i_last = 1'b0;
  logic                   i_mode = 1'b0;
  logic [DW*TIN-1:0]      i_dat = '0;
  logic [DW*TIN*TOUT-1:0] i_wt = '0;
  logic                   o_vld;
  logic [ACC_W*TOUT-1:0]  o_dat;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  exp_t        sb[$];
  longint      macc[TOUT];
  bit          first = 1'b1;

  vs_vmm_acc #(
    .DW(DW), .TIN(TIN), .TOUT(TOUT), .ACC_GUARD(GUARD), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_last(i_last), .i_mode(i_mode),
    .i_dat(i_dat), .i_wt(i_wt), .o_vld(o_vld), .o_dat(o_dat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] lane_model(input longint v, input logic mode);
    longint r;
    r = v;
`ifdef VS_VMM_SAT_EN
    if (mode) begin
      if (r > (longint'(1) << (OUT_W-1)) - 1) r = (longint'(1) << (OUT_W-1)) - 1;
      if (r < -(longint'(1) << (OUT_W-1)))    r = -(longint'(1) << (OUT_W-1));
    end else if (r > (longint'(1) << OUT_W) - 1) begin
      r = (longint'(1) << OUT_W) - 1;
    end
`else
    if (mode) r = v;
`endif
    return r[ACC_W-1:0];
  endfunction

  function automatic logic [DW*TIN-1:0] rep_dat(input logic [DW-1:0] v);
    logic [DW*TIN-1:0] r;
    for (int k = 0; k < TIN; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [DW*TIN*TOUT-1:0] rep_wt(input logic [DW-1:0] v);
    logic [DW*TIN*TOUT-1:0] r;
    for (int k = 0; k < TIN*TOUT; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  task automatic beat(input logic [DW*TIN-1:0] d, input logic [DW*TIN*TOUT-1:0] w,
                      input logic last, input logic mode);
    longint p, a, b;
    logic [DW-1:0] wk;
    exp_t e;
    @(posedge clk); #1;
    i_vld = 1'b1; i_last = last; i_mode = mode; i_dat = d; i_wt = w;
    for (int j = 0; j < TOUT; j++) begin
      p = 0;
      for (int k = 0; k < TIN; k++) begin
        wk = w[(j*TIN+k)*DW +: DW];
        a = mode ? longint'($signed(d[k*DW +: DW])) : longint'(d[k*DW +: DW]);
        b = mode ? longint'($signed(wk)) : longint'(wk);
        p += a * b;
      end
      macc[j] = first ? p : macc[j] + p;
    end
    first = last;
    if (last) begin
      for (int j = 0; j < TOUT; j++) e.dat[j*ACC_W +: ACC_W] = lane_model(macc[j], mode);
      e.cyc = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_vld = 1'b0; i_last = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_vld) begin
        if (sb.size() == 0) begin
          check_eq("unexp_vld", 128'(o_vld), 128'd0);
        end else begin
          e = sb.pop_front();
          check_eq("lane_dat", 128'(o_dat), 128'(e.dat));
          check_eq("latency", 128'(cyc), 128'(e.cyc));
        end
      end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
        check_eq("vld_at_lat", 128'(o_vld), 128'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [DW*TIN*TOUT-1:0] w;
    logic [DW*TIN-1:0]      d;
    int                     len;
    logic                   m;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_vld", 128'(o_vld), 128'd0);
    check_eq("rst_dat", 128'(o_dat), 128'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst_vld", 128'(o_vld), 128'd0);
      check_eq("post_rst_dat", 128'(o_dat), 128'd0);
    end

    // Single beat, column j weights j+1 -> 4,8,12,16
    for (int j = 0; j < TOUT; j++)
      for (int k = 0; k < TIN; k++) w[(j*TIN+k)*DW +: DW] = DW'(j + 1);
    beat(rep_dat(8'd1), w, 1'b1, 1'b0);
    idle(10);

    // Three beats with 2-cycle bubbles -> 24 per lane
    beat(rep_dat(8'd1), rep_wt(8'd1), 1'b0, 1'b0); idle(2);
    beat(rep_dat(8'd2), rep_wt(8'd1), 1'b0, 1'b0); idle(2);
    beat(rep_dat(8'd3), rep_wt(8'd1), 1'b1, 1'b0);
    idle(10);

    beat(rep_dat(8'hFF), rep_wt(8'd2), 1'b1, 1'b1);
    beat(rep_dat(8'hFF), rep_wt(8'd2), 1'b1, 1'b0);
    idle(10);

    beat(rep_dat(8'd1), rep_wt(8'd1), 1'b1, 1'b0);
    beat(rep_dat(8'd2), rep_wt(8'd1), 1'b1, 1'b0);
    idle(12);

    // Abort a group with reset, then a fresh single-beat group
    beat(rep_dat(8'd5), rep_wt(8'd3), 1'b0, 1'b0);
    beat(rep_dat(8'd7), rep_wt(8'd3), 1'b0, 1'b0);
    @(posedge clk); #1;
    i_vld = 1'b0; i_last = 1'b0; rst_n = 1'b0; first = 1'b1;
    @(negedge clk);
    check_eq("midrst_dat", 128'(o_dat), 128'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    beat(rep_dat(8'd1), rep_wt(8'd1), 1'b1, 1'b0);
    idle(12);

    beat(rep_dat(8'd127), rep_wt(8'd127), 1'b1, 1'b1);
    beat(rep_dat(8'h80),  rep_wt(8'd127), 1'b1, 1'b1);
    beat(rep_dat(8'hFF),  rep_wt(8'hFF),  1'b1, 1'b0);
    idle(4);

    for (int g = 0; g < 20; g++) begin
      len = $urandom_range(1, 4);
      m = 1'($urandom_range(0, 1));
      for (int b = 0; b < len; b++) begin
        for (int k = 0; k < TIN; k++) d[k*DW +: DW] = DW'($urandom);
        for (int k = 0; k < TIN*TOUT; k++) w[k*DW +: DW] = DW'($urandom);
        beat(d, w, b == len - 1, m);
        idle($urandom_range(0, 2));
      end
    end

    idle(20);
    check_eq("sb_drained", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
